// File: rtl/moore_serial_pkg.sv
// Shared state encoding and width helpers for the Moore serial transmitter.
// Pure declarations; no logic, no latency.
package moore_serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  // ones_cnt must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int calc_cw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/moore_serial_shreg.sv
// Parallel-load, left-shift register; MSB is exposed as the serial bit.
// Load takes priority over shift; one cycle to load, zeros shift in at the LSB.
module moore_serial_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_b,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge CLK or negedge RST_b) begin
    if (!RST_b) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/moore_serial_tx.sv
// Moore serial transmitter: word accepted in IDLE, sent MSB-first over WIDTH cycles,
// then one DONE cycle and GAP idle cycles; din_ready is low for the whole frame.
module moore_serial_tx
  import moore_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  parameter int CW    = calc_cw(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_b,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_done,
  output logic [CW-1:0]    ones_cnt
);

  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_SHIFT = S_SHIFT;
  localparam logic [1:0] ST_DONE  = S_DONE;
  localparam logic [1:0] ST_GAP   = S_GAP;

  localparam int BW = $clog2(WIDTH);
  // Keep the gap counter at least one bit wide even when the GAP state is unreachable.
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [BW-1:0] bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic          msb;
  logic          accept;

  assign accept = (state == ST_IDLE) && din_valid;

  moore_serial_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .CLK   (CLK),
    .RST_b (RST_b),
    .load  (accept),
    .shift (state == ST_SHIFT),
    .din   (din),
    .msb   (msb)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (din_valid) state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_cnt == BIT_LAST) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_b) begin
    if (!RST_b) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      ones_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (din_valid) begin
            bit_cnt  <= '0;
            ones_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          bit_cnt  <= bit_cnt + 1'b1;
          ones_cnt <= ones_cnt + CW'(msb);
        end
        ST_DONE: gap_cnt <= '0;
        ST_GAP:  gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs depend on state and registers only.
  assign din_ready  = (state == ST_IDLE);
  assign x_valid    = (state == ST_SHIFT);
  assign x_out      = x_valid && msb;
  assign frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_moore_serial_tx.sv
// Directed bench for moore_serial_tx: default (8,2), zero-gap (8,0) and minimum-width (2,2) instances.
module tb_moore_serial_tx;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST_b;

  logic [7:0] din_a;
  logic       vld_a;
  logic       rdy_a, x_a, xv_a, fd_a;
  logic [3:0] oc_a;

  logic [7:0] din_b;
  logic       vld_b;
  logic       rdy_b, x_b, xv_b, fd_b;
  logic [3:0] oc_b;

  logic [1:0] din_c;
  logic       vld_c;
  logic       rdy_c, x_c, xv_c, fd_c;
  logic [1:0] oc_c;

  int errors = 0;
  int checks = 0;

  moore_serial_tx #(.WIDTH(8), .GAP(2)) dut_a (
    .CLK(CLK), .RST_b(RST_b), .din(din_a), .din_valid(vld_a), .din_ready(rdy_a),
    .x_out(x_a), .x_valid(xv_a), .frame_done(fd_a), .ones_cnt(oc_a)
  );

  moore_serial_tx #(.WIDTH(8), .GAP(0)) dut_b (
    .CLK(CLK), .RST_b(RST_b), .din(din_b), .din_valid(vld_b), .din_ready(rdy_b),
    .x_out(x_b), .x_valid(xv_b), .frame_done(fd_b), .ones_cnt(oc_b)
  );

  moore_serial_tx #(.WIDTH(2), .GAP(2)) dut_c (
    .CLK(CLK), .RST_b(RST_b), .din(din_c), .din_valid(vld_c), .din_ready(rdy_c),
    .x_out(x_c), .x_valid(xv_c), .frame_done(fd_c), .ones_cnt(oc_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed as {din_ready, x_valid, x_out, frame_done, ones_cnt}.
  task automatic st_a(input string tag, input logic rdy, input logic xv, input logic x,
                      input logic fd, input logic [3:0] oc);
    chk(tag, 32'({rdy_a, xv_a, x_a, fd_a, oc_a}), 32'({rdy, xv, x, fd, oc}));
  endtask

  task automatic st_b(input string tag, input logic rdy, input logic xv, input logic x,
                      input logic fd, input logic [3:0] oc);
    chk(tag, 32'({rdy_b, xv_b, x_b, fd_b, oc_b}), 32'({rdy, xv, x, fd, oc}));
  endtask

  task automatic st_c(input string tag, input logic rdy, input logic xv, input logic x,
                      input logic fd, input logic [1:0] oc);
    chk(tag, 32'({rdy_c, xv_c, x_c, fd_c, oc_c}), 32'({rdy, xv, x, fd, oc}));
  endtask

  // Called in the first bit cycle; returns in the frame_done cycle.
  task automatic bits_a(input string tag, input logic [7:0] pat);
    for (int i = 7; i >= 0; i--) begin
      chk(tag, 32'({rdy_a, xv_a, x_a, fd_a}), 32'({1'b0, 1'b1, pat[i], 1'b0}));
      @(negedge CLK);
    end
  endtask

  initial begin
    RST_b = 1'b0;
    din_a = '0; vld_a = 1'b0;
    din_b = '0; vld_b = 1'b0;
    din_c = '0; vld_c = 1'b0;

    #2;
    st_a("rst_a", 1, 0, 0, 0, 4'd0);
    st_b("rst_b", 1, 0, 0, 0, 4'd0);
    st_c("rst_c", 1, 0, 0, 0, 2'd0);
    #10 RST_b = 1'b1;

    // Idle with no valid
    repeat (4) begin
      @(negedge CLK);
      st_a("idle", 1, 0, 0, 0, 4'd0);
    end

    // Single frame 0xB4
    din_a = 8'hB4; vld_a = 1'b1;
    @(negedge CLK);
    vld_a = 1'b0; din_a = 8'h00;
    bits_a("b4_bit", 8'hB4);
    st_a("b4_done", 0, 0, 0, 1, 4'd4);
    @(negedge CLK); st_a("b4_gap1", 0, 0, 0, 0, 4'd4);
    @(negedge CLK); st_a("b4_gap2", 0, 0, 0, 0, 4'd4);
    @(negedge CLK); st_a("b4_ready", 1, 0, 0, 0, 4'd4);

    // Back-to-back 0xFF then 0x01, din disturbed during SHIFT
    din_a = 8'hFF; vld_a = 1'b1;
    @(negedge CLK);
    din_a = 8'h00;
    bits_a("ff_bit", 8'hFF);
    st_a("ff_done", 0, 0, 0, 1, 4'd8);
    din_a = 8'h01;
    @(negedge CLK);
    @(negedge CLK); st_a("ff_gap", 0, 0, 0, 0, 4'd8);
    @(negedge CLK); st_a("ff_ready", 1, 0, 0, 0, 4'd8);
    @(negedge CLK);
    vld_a = 1'b0;
    st_a("01_start", 0, 1, 0, 0, 4'd0);
    bits_a("01_bit", 8'h01);
    st_a("01_done", 0, 0, 0, 1, 4'd1);
    repeat (3) @(negedge CLK);
    st_a("01_idle", 1, 0, 0, 0, 4'd1);

    // Asynchronous reset mid-frame of 0xAA
    din_a = 8'hAA; vld_a = 1'b1;
    @(negedge CLK);
    vld_a = 1'b0; din_a = 8'h00;
    repeat (4) @(negedge CLK);
    st_a("aa_mid", 0, 1, 1, 0, 4'd2);
    #2 RST_b = 1'b0;
    #1 st_a("aa_rst", 1, 0, 0, 0, 4'd0);
    #1 RST_b = 1'b1;
    repeat (12) begin
      @(negedge CLK);
      st_a("aa_quiet", 1, 0, 0, 0, 4'd0);
    end
    din_a = 8'h5A; vld_a = 1'b1;
    @(negedge CLK);
    vld_a = 1'b0; din_a = 8'h00;
    bits_a("5a_bit", 8'h5A);
    st_a("5a_done", 0, 0, 0, 1, 4'd4);
    repeat (3) @(negedge CLK);
    st_a("5a_idle", 1, 0, 0, 0, 4'd4);

    // Zero gap, back-to-back 0x00
    din_b = 8'h00; vld_b = 1'b1;
    @(negedge CLK);
    repeat (8) begin
      st_b("z1_bit", 0, 1, 0, 0, 4'd0);
      @(negedge CLK);
    end
    st_b("z1_done", 0, 0, 0, 1, 4'd0);
    @(negedge CLK); st_b("z1_ready", 1, 0, 0, 0, 4'd0);
    @(negedge CLK); st_b("z2_start", 0, 1, 0, 0, 4'd0);
    vld_b = 1'b0;
    repeat (7) begin
      @(negedge CLK);
      st_b("z2_bit", 0, 1, 0, 0, 4'd0);
    end
    @(negedge CLK); st_b("z2_done", 0, 0, 0, 1, 4'd0);
    @(negedge CLK); st_b("z2_idle", 1, 0, 0, 0, 4'd0);

    // Minimum width, 2'b10
    din_c = 2'b10; vld_c = 1'b1;
    @(negedge CLK);
    vld_c = 1'b0; din_c = 2'b00;
    st_c("w2_bit1", 0, 1, 1, 0, 2'd0);
    @(negedge CLK); st_c("w2_bit0", 0, 1, 0, 0, 2'd1);
    @(negedge CLK); st_c("w2_done", 0, 0, 0, 1, 2'd1);
    @(negedge CLK); st_c("w2_gap1", 0, 0, 0, 0, 2'd1);
    @(negedge CLK); st_c("w2_gap2", 0, 0, 0, 0, 2'd1);
    @(negedge CLK); st_c("w2_ready", 1, 0, 0, 0, 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
